// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state encoding.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    FUNC_ADD = 2'b00,
    FUNC_SUB = 2'b01,
    FUNC_MUL = 2'b10,
    FUNC_DIV = 2'b11
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle of seq_alu; the master issues operations, the ALU is the slave.
// Handshake: start is a request that is accepted on a rising edge only while busy is low
// (it is ignored otherwise, never queued); each accepted request produces exactly one
// one-cycle done pulse, and out/overflow/div_by_zero are valid from done until the next result.
interface seq_alu_if
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 6
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           func;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   out;
  logic                 overflow;
  logic                 div_by_zero;
  state_t               dbg_state;

  modport master (
    output start, a, b, func,
    input  busy, done, out, overflow, div_by_zero, dbg_state
  );

  modport slave (
    input  start, a, b, func,
    output busy, done, out, overflow, div_by_zero, dbg_state
  );
endinterface

// File: rtl/seq_alu_divider.sv
// Unsigned restoring divider, one quotient bit per clock, WIDTH iterations after load.
// ready marks the cycle whose edge completes the last iteration; quotient/remainder show that result.
module seq_alu_divider #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] step_rem, step_quo;

  always_comb begin
    // Shift the next dividend bit into the partial remainder and trial-subtract.
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    step_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign quotient  = step_quo;
  assign remainder = step_rem;
  assign ready     = active_q && (cnt_q == LAST);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/mul, multi-cycle division through seq_alu_divider.
// Define SEQ_ALU_SIGNED_DIV_EN for signed division; the default build divides unsigned.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  state_t          state_q, state_d;
  logic [W2-1:0]   out_q, out_d;
  logic            ovf_q, ovf_d, dbz_q, dbz_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, div_ovf_q, div_ovf_d;

  func_t            func;
  logic             accept, div_load, div_ready;
  logic             q_neg_in, r_neg_in, div_ovf_in;
  logic [WIDTH-1:0] dvd_in, dvs_in, quo_raw, rem_raw, quo_fix, rem_fix;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [W2-1:0]    a_wide, b_wide, prod;

  assign func     = func_t'(bus.func);
  assign accept   = (state_q == IDLE) && bus.start;
  assign div_load = accept && (func == FUNC_DIV) && (bus.b != '0);

  always_comb begin
    sum_ext = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
    dif_ext = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
    a_wide  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
    b_wide  = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    prod    = a_wide * b_wide;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    // MIN negates to itself, which is still the correct unsigned magnitude.
    dvd_in     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    dvs_in     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    q_neg_in   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    r_neg_in   = bus.a[WIDTH-1];
    div_ovf_in = (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
`else
    dvd_in     = bus.a;
    dvs_in     = bus.b;
    q_neg_in   = 1'b0;
    r_neg_in   = 1'b0;
    div_ovf_in = 1'b0;
`endif
    quo_fix = q_neg_q ? -quo_raw : quo_raw;
    rem_fix = r_neg_q ? -rem_raw : rem_raw;
  end

  seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (dvd_in),
    .divisor   (dvs_in),
    .quotient  (quo_raw),
    .remainder (rem_raw),
    .ready     (div_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      div_ovf_q <= div_ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = div_load ? DIV : DONE;
      DIV:     if (div_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div_ovf_d = div_ovf_q;
    if (accept) begin
      case (func)
        FUNC_ADD: begin
          out_d = {{WIDTH{sum_ext[WIDTH-1]}}, sum_ext[WIDTH-1:0]};
          ovf_d = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
          dbz_d = 1'b0;
        end
        FUNC_SUB: begin
          out_d = {{WIDTH{dif_ext[WIDTH-1]}}, dif_ext[WIDTH-1:0]};
          ovf_d = dif_ext[WIDTH] ^ dif_ext[WIDTH-1];
          dbz_d = 1'b0;
        end
        FUNC_MUL: begin
          out_d = prod;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
        end
        FUNC_DIV: begin
          if (bus.b == '0) begin
            out_d = {{WIDTH{1'b1}}, bus.a};
            ovf_d = 1'b0;
            dbz_d = 1'b1;
          end else begin
            // Result lands later; only the sign fix-up context is captured now.
            q_neg_d   = q_neg_in;
            r_neg_d   = r_neg_in;
            div_ovf_d = div_ovf_in;
          end
        end
        default: ;
      endcase
    end else if ((state_q == DIV) && div_ready) begin
      out_d = {quo_fix, rem_fix};
      ovf_d = div_ovf_q;
      dbz_d = 1'b0;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.out         = out_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=6: vector table plus hand-written busy/start/reset sequences.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W       = 6;
  localparam int W2      = 2 * W;
  localparam int MAX_LAT = 40;

  typedef struct {
    logic [1:0]    f;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W2-1:0] out;
    logic          ovf;
    logic          dbz;
    int            lat;
  } vec_t;

  logic          clk;
  logic          rst;
  int            checks;
  int            errors;
  vec_t          vecs[$];
  logic [W2-1:0] exp_q[$];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W2-1:0] r_out, output logic r_ovf, output logic r_dbz,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = f;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    lat     = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < MAX_LAT) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.busy) busy_ok = 1'b0;
    r_out = bus.out;
    r_ovf = bus.overflow;
    r_dbz = bus.div_by_zero;
  endtask

  task automatic start_div(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = FUNC_DIV;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W2-1:0] r_out;
    logic [W2-1:0] exp;
    logic          r_ovf;
    logic          r_dbz;
    logic          busy_ok;
    int            lat;
    int            n_done;
    logic [W2-1:0] got;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.func  = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    vecs.push_back('{FUNC_ADD, 6'h1F, 6'h01, 12'hFE0, 1'b1, 1'b0, 1});
    vecs.push_back('{FUNC_ADD, 6'h05, 6'h03, 12'h008, 1'b0, 1'b0, 1});
    vecs.push_back('{FUNC_SUB, 6'h20, 6'h01, 12'h01F, 1'b1, 1'b0, 1});
    vecs.push_back('{FUNC_SUB, 6'h03, 6'h05, 12'hFFE, 1'b0, 1'b0, 1});
    vecs.push_back('{FUNC_MUL, 6'h20, 6'h20, 12'h400, 1'b0, 1'b0, 1});
    vecs.push_back('{FUNC_MUL, 6'h3F, 6'h05, 12'hFFB, 1'b0, 1'b0, 1});
    vecs.push_back('{FUNC_MUL, 6'h1F, 6'h1F, 12'h3C1, 1'b0, 1'b0, 1});
    vecs.push_back('{FUNC_DIV, 6'd27, 6'd5,  12'h142, 1'b0, 1'b0, 7});
    vecs.push_back('{FUNC_DIV, 6'd9,  6'd0,  12'hFC9, 1'b0, 1'b1, 1});
    vecs.push_back('{FUNC_ADD, 6'h01, 6'h01, 12'h002, 1'b0, 1'b0, 1});
    vecs.push_back('{FUNC_DIV, 6'h3F, 6'h01, 12'hFC0, 1'b0, 1'b0, 7});
    vecs.push_back('{FUNC_DIV, 6'h07, 6'h09, 12'h007, 1'b0, 1'b0, 7});
`ifdef SEQ_ALU_SIGNED_DIV_EN
    vecs.push_back('{FUNC_DIV, 6'h25, 6'h05, 12'hEFE, 1'b0, 1'b0, 7});
    vecs.push_back('{FUNC_DIV, 6'h20, 6'h3F, 12'h800, 1'b1, 1'b0, 7});
    vecs.push_back('{FUNC_DIV, 6'h07, 6'h3E, 12'hF41, 1'b0, 1'b0, 7});
`else
    vecs.push_back('{FUNC_DIV, 6'h25, 6'h05, 12'h1C2, 1'b0, 1'b0, 7});
    vecs.push_back('{FUNC_DIV, 6'h20, 6'h3F, 12'h020, 1'b0, 1'b0, 7});
    vecs.push_back('{FUNC_DIV, 6'h3F, 6'h3E, 12'h041, 1'b0, 1'b0, 7});
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_out",  bus.out, '0);
    check("reset_busy", W2'(bus.busy), '0);
    check("reset_done", W2'(bus.done), '0);
    check("reset_ovf",  W2'(bus.overflow), '0);
    check("reset_dbz",  W2'(bus.div_by_zero), '0);
    rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].out);
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, r_out, r_ovf, r_dbz, lat, busy_ok);
      exp = exp_q.pop_front();
      check($sformatf("v%0d_out", i), r_out, exp);
      check($sformatf("v%0d_ovf", i), W2'(r_ovf), W2'(vecs[i].ovf));
      check($sformatf("v%0d_dbz", i), W2'(r_dbz), W2'(vecs[i].dbz));
      check($sformatf("v%0d_latency", i), W2'(lat), W2'(vecs[i].lat));
      check($sformatf("v%0d_busy", i), W2'(busy_ok), W2'(1'b1));
      @(negedge clk);
      check($sformatf("v%0d_done_width", i), W2'(bus.done), '0);
      check($sformatf("v%0d_idle_busy", i), W2'(bus.busy), '0);
      check($sformatf("v%0d_out_hold", i), bus.out, vecs[i].out);
    end

    // start pulsed mid-division is dropped, not queued
    start_div(6'd27, 6'd5);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = FUNC_ADD;
    bus.a     = 6'd1;
    bus.b     = 6'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0;
    got    = '0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        got = bus.out;
      end
    end
    check("ignored_start_done_count", W2'(n_done), W2'(1));
    check("ignored_start_out", got, 12'h142);
    check("ignored_start_idle", W2'(bus.busy), '0);

    // Leave div_by_zero set so the abort below shows it clearing
    run_op(FUNC_DIV, 6'd9, 6'd0, r_out, r_ovf, r_dbz, lat, busy_ok);
    check("pre_abort_dbz", W2'(r_dbz), W2'(1'b1));

    // Reset during the fourth division cycle
    start_div(6'd27, 6'd5);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", W2'(bus.busy), '0);
    check("abort_out",  bus.out, '0);
    check("abort_done", W2'(bus.done), '0);
    check("abort_dbz",  W2'(bus.div_by_zero), '0);
    check("abort_ovf",  W2'(bus.overflow), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", W2'(n_done), '0);

    run_op(FUNC_DIV, 6'd27, 6'd5, r_out, r_ovf, r_dbz, lat, busy_ok);
    check("after_abort_out", r_out, 12'h142);
    check("after_abort_latency", W2'(lat), W2'(7));
    check("after_abort_busy", W2'(busy_ok), W2'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 6, giving the operand width in bits (legal range 4..16).
REQ-002 SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have input start, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have input a, WIDTH bits: signed operand A.
REQ-006 SHALL have input b, WIDTH bits: signed operand B.
REQ-007 SHALL have input func, 2 bits: operation select (00 add, 01 sub, 10 mul, 11 div).
REQ-008 SHALL have output busy, 1 bit: high in any state other than IDLE.
REQ-009 SHALL have output done, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have output out, 2*WIDTH bits: registered result.
REQ-011 SHALL have output overflow, 1 bit: signed overflow flag for the last result.
REQ-012 SHALL have output div_by_zero, 1 bit: set when the last division had b == 0.

Function
REQ-013 SHALL use FSM states IDLE, DIV, DONE.
REQ-014 SHALL, on a rising edge in IDLE with start=1, latch a, b and func, called acceptance.
REQ-015 SHALL ignore start in DIV and DONE, with no queuing.
REQ-016 SHALL, for add/sub/mul and for div with b == 0, go IDLE->DONE at acceptance, so done is high for the cycle after the accepting edge (latency 1).
REQ-017 SHALL, for div with b != 0, go IDLE->DIV, run WIDTH restoring iterations (one per cycle, counter 0..WIDTH-1), then DONE, so done is high after WIDTH+1 edges.
REQ-018 SHALL go DONE->IDLE unconditionally, so done is exactly one cycle wide.
REQ-019 SHALL hold out, overflow and div_by_zero stable from done until the next result is written.
REQ-020 SHALL, for add/sub, put the WIDTH-bit wrapped result in out[WIDTH-1:0] and its sign extension in out[2W-1:WIDTH].
REQ-021 SHALL, for add/sub, set overflow=1 iff the true signed result lies outside [-2^(W-1), 2^(W-1)-1].
REQ-022 SHALL, for mul, return the full 2W-bit signed product with overflow=0.
REQ-023 SHALL, for div, put the quotient in out[2W-1:WIDTH] and the remainder in out[WIDTH-1:0].
REQ-024 SHALL, for div with b == 0, return quotient all-ones and remainder a, with div_by_zero=1 and overflow=0.
REQ-025 SHALL clear div_by_zero on every non-div-by-zero result.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, clear the iteration counter, and drive out=0, overflow=0, div_by_zero=0, done=0, busy=0 immediately, independent of clk.
REQ-027 SHALL, when rst asserts mid-division, abort the operation with no done pulse; the next acceptance behaves as from a fresh reset.

Configuration
REQ-028 SHALL provide the macro SEQ_ALU_SIGNED_DIV_EN.
REQ-029 SHALL, when the macro is defined, treat division as signed:
- magnitudes are fed to the divider;
- the quotient truncates toward zero;
- the remainder takes the sign of the dividend;
- MIN / -1 yields quotient MIN, remainder 0, overflow=1.
REQ-030 SHALL, when the macro is undefined, treat a and b as unsigned for division, with overflow always 0 for div.
REQ-031 SHALL leave add/sub/mul identical in both builds.

Structure
REQ-032 SHALL place the func codes and the FSM state enum in shared package seq_alu_pkg.
REQ-033 SHALL implement the iterative restoring divider as sub-module seq_alu_divider:
- parameter WIDTH;
- ports clk, rst, load, dividend, divisor, quotient, remainder, ready;
- unsigned core; sign handling stays in seq_alu.

Verification (WIDTH=6)
REQ-034 SHALL check: add 31+1 -> out[5:0]=6'h20 (-32), overflow=1, done 1 cycle after accept.
REQ-035 SHALL check: mul -32*-32 -> out=12'h400, overflow=0; mul -1*5 -> out=12'hFFB.
REQ-036 SHALL check: div 27/5 -> quotient 5, remainder 2; done exactly 7 edges after accept; busy high for those cycles.
REQ-037 SHALL check:
- signed build: -27/5 -> quotient -5, remainder -2; -32/-1 -> quotient -32, overflow=1;
- unsigned build: 6'h25/5 -> quotient 7, remainder 2.
REQ-038 SHALL check: div 9/0 -> quotient 6'h3F, remainder 9, div_by_zero=1, latency 1.
REQ-039 SHALL check:
- start pulsed during DIV is ignored (single done);
- rst at DIV cycle 3 -> busy=0 and out=0 at once, no done; a new 27/5 afterwards returns 5 remainder 2.
